lsu_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_ctrl_if.sv | 12 +
 rtl/lsu_load_align.sv | 19 +
 rtl/lsu_ctrl.sv | 106 ++++++++++
 tb/tb_lsu_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and lane/legality helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_e;
  // Legal and naturally aligned; unsigned widths only exist for loads
  function automatic logic lsu_ok(input logic wren, input logic [2:0] f3, input logic [1:0] a);
    return f3 == LSU_B  ? 1'b1 :
           f3 == LSU_BU ? !wren :
           f3 == LSU_H  ? !a[0] :
           f3 == LSU_HU ? !wren && !a[0] :
           f3 == LSU_W  ? a == 2'b00 : 1'b0;
  endfunction
  function automatic logic [3:0] lsu_bmask(input logic [1:0] sz, input logic [1:0] a);
    return sz == 2'b00 ? 4'b0001 << a : sz == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] lsu_wrep(input logic [1:0] sz, input logic [31:0] d);
    return sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory req/ack bus between the LSU and memory
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_bmask, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_bmask, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half from a memory word and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_ofs,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = i_ofs == 2'd0 ? i_word[7:0] : i_ofs == 2'd1 ? i_word[15:8] :
             i_ofs == 2'd2 ? i_word[23:16] : i_word[31:24];
  assign h = i_ofs[1] ? i_word[31:16] : i_word[15:0];
  assign o_data = i_funct3 == LSU_B  ? {{24{b[7]}}, b} :
                  i_funct3 == LSU_BU ? {24'b0, b} :
                  i_funct3 == LSU_H  ? {{16{h[15]}}, h} :
                  i_funct3 == LSU_HU ? {16'b0, h} : i_word;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage running one req/ack bus transaction per op
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_misalign,
  output logic        o_lsu_buserr,
  lsu_ctrl_if.master  mem
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, ext;
  logic [2:0]  f3_q, f3_d;
  logic        wren_q, wren_d, mis_q, mis_d, berr_q, berr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ok, take, acc, tmo;
  assign ok   = lsu_ok(i_lsu_wren, i_lsu_funct3, i_lsu_addr[1:0]);
  assign take = i_lsu_valid && state_q == IDLE;
  assign acc  = state_q == ACCESS;
  assign tmo  = TIMEOUT_CYC != 0 && cnt_q + 1'b1 == CW'(TIMEOUT_CYC);
  // Next-state: accept in IDLE, wait for ack or timeout in ACCESS, one-cycle DONE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    wren_d  = wren_q;
    word_d  = word_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;
    if (take) begin
      addr_d  = i_lsu_addr;
      wdata_d = i_lsu_wdata;
      f3_d    = i_lsu_funct3;
      wren_d  = i_lsu_wren;
      mis_d   = !ok;
      berr_d  = 1'b0;
      cnt_d   = '0;
      state_d = ok ? ACCESS : DONE;
    end else if (acc) begin
      if (mem.mem_ack) begin
        word_d  = mem.mem_rdata;
        state_d = DONE;
      end else if (tmo) begin
        berr_d  = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State and operand registers; reset discards any op in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wren_q  <= 1'b0;
      word_q  <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      wren_q  <= wren_d;
      word_q  <= word_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end
  lsu_load_align u_align (
    .i_word   (word_q),
    .i_ofs    (addr_q[1:0]),
    .i_funct3 (f3_q),
    .o_data   (ext)
  );
  assign o_lsu_ready    = state_q == IDLE;
  assign o_lsu_done     = state_q == DONE;
  assign o_lsu_misalign = o_lsu_done && mis_q;
  assign o_lsu_buserr   = o_lsu_done && berr_q;
  assign o_lsu_rdata    = o_lsu_done && !mis_q && !berr_q && !wren_q ? ext : '0;
  assign mem.mem_req    = acc;
  assign mem.mem_we     = acc && wren_q;
  assign mem.mem_addr   = acc ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_bmask  = acc ? lsu_bmask(f3_q[1:0], addr_q[1:0]) : '0;
  assign mem.mem_wdata  = acc && wren_q ? lsu_wrep(f3_q[1:0], wdata_q) : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors with hand-computed expectations for lsu_ctrl
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        wren = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, mis, berr;
  logic [31:0] rdata;
  int vec = 0;
  int bad = 0;
  lsu_ctrl_if mem ();
  lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_lsu_valid    (valid),
    .i_lsu_wren     (wren),
    .i_lsu_funct3   (f3),
    .i_lsu_addr     (addr),
    .i_lsu_wdata    (wdata),
    .o_lsu_ready    (ready),
    .o_lsu_done     (done),
    .o_lsu_rdata    (rdata),
    .o_lsu_misalign (mis),
    .o_lsu_buserr   (berr),
    .mem            (mem)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1;
    wren  = w;
    f3    = f;
    addr  = a;
    wdata = d;
  endtask
  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_req", mem.mem_req, 1'b0);
    chk1("rst_we", mem.mem_we, 1'b0);
    chk("rst_addr", mem.mem_addr, 32'h0);
    chk("rst_bmask", {28'b0, mem.mem_bmask}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk1("rst_mis", mis, 1'b0);
    chk1("rst_berr", berr, 1'b0);
    // SB 0x1003, ack on third ACCESS cycle
    op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    tick();
    valid = 1'b0;
    chk1("sb_req", mem.mem_req, 1'b1);
    chk1("sb_we", mem.mem_we, 1'b1);
    chk1("sb_ready", ready, 1'b0);
    chk("sb_addr", mem.mem_addr, 32'h0000_1000);
    chk("sb_bmask", {28'b0, mem.mem_bmask}, 32'h8);
    chk("sb_wdata", mem.mem_wdata, 32'hABAB_ABAB);
    tick();
    chk1("sb_req2", mem.mem_req, 1'b1);
    chk1("sb_done2", done, 1'b0);
    tick();
    chk1("sb_req3", mem.mem_req, 1'b1);
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    chk1("sb_done", done, 1'b1);
    chk("sb_rdata", rdata, 32'h0);
    chk1("sb_req_off", mem.mem_req, 1'b0);
    chk1("sb_mis", mis, 1'b0);
    tick();
    chk1("sb_done_off", done, 1'b0);
    chk1("sb_ready_back", ready, 1'b1);
    // LB 0x2002, immediate ack
    op(1'b0, 3'b000, 32'h0000_2002, 32'h0);
    tick();
    valid = 1'b0;
    chk1("lb_done_early", done, 1'b0);
    chk1("lb_we", mem.mem_we, 1'b0);
    chk("lb_bmask", {28'b0, mem.mem_bmask}, 32'h4);
    chk("lb_addr", mem.mem_addr, 32'h0000_2000);
    mem.mem_ack = 1'b1;
    mem.mem_rdata = 32'h12F4_5678;
    tick();
    mem.mem_ack = 1'b0;
    chk1("lb_done", done, 1'b1);
    chk("lb_rdata", rdata, 32'hFFFF_FFF4);
    tick();
    // LBU same address
    op(1'b0, 3'b100, 32'h0000_2002, 32'h0);
    tick();
    valid = 1'b0;
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    chk1("lbu_done", done, 1'b1);
    chk("lbu_rdata", rdata, 32'h0000_00F4);
    tick();
    // LH at upper half, negative
    op(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    tick();
    valid = 1'b0;
    chk("lh_bmask", {28'b0, mem.mem_bmask}, 32'hC);
    mem.mem_ack = 1'b1;
    mem.mem_rdata = 32'h8001_7FFF;
    tick();
    mem.mem_ack = 1'b0;
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    tick();
    // LH misaligned
    op(1'b0, 3'b001, 32'h0000_2001, 32'h0);
    mem.mem_rdata = 32'hFFFF_FFFF;
    tick();
    valid = 1'b0;
    chk1("lhm_done", done, 1'b1);
    chk1("lhm_mis", mis, 1'b1);
    chk1("lhm_req", mem.mem_req, 1'b0);
    chk("lhm_rdata", rdata, 32'h0);
    tick();
    chk1("lhm_done_off", done, 1'b0);
    chk1("lhm_mis_off", mis, 1'b0);
    chk1("lhm_req_off", mem.mem_req, 1'b0);
    // store with funct3 100 is illegal
    op(1'b1, 3'b100, 32'h0000_3000, 32'h1234_5678);
    tick();
    valid = 1'b0;
    chk1("sbu_done", done, 1'b1);
    chk1("sbu_mis", mis, 1'b1);
    chk1("sbu_req", mem.mem_req, 1'b0);
    chk1("sbu_we", mem.mem_we, 1'b0);
    tick();
    // LW 0x40 with no ack: eight request cycles then bus error
    op(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("to_req", mem.mem_req, 1'b1);
      chk1("to_done", done, 1'b0);
      tick();
    end
    chk1("to_done_pulse", done, 1'b1);
    chk1("to_berr", berr, 1'b1);
    chk1("to_req_off", mem.mem_req, 1'b0);
    chk("to_rdata", rdata, 32'h0);
    tick();
    chk1("to_berr_off", berr, 1'b0);
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    chk1("stray_done", done, 1'b0);
    chk1("stray_ready", ready, 1'b1);
    // ack in the timeout cycle wins
    op(1'b0, 3'b010, 32'h0000_0044, 32'h0);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk1("race_req", mem.mem_req, 1'b1);
    mem.mem_ack = 1'b1;
    mem.mem_rdata = 32'h5A5A_0F0F;
    tick();
    mem.mem_ack = 1'b0;
    chk1("race_done", done, 1'b1);
    chk1("race_berr", berr, 1'b0);
    chk("race_rdata", rdata, 32'h5A5A_0F0F);
    tick();
    // reset mid-ACCESS
    op(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    tick();
    valid = 1'b0;
    chk1("rm_req", mem.mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rm_req_off", mem.mem_req, 1'b0);
    chk1("rm_ready", ready, 1'b1);
    chk1("rm_done", done, 1'b0);
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    chk1("rm_ack_done", done, 1'b0);
    chk1("rm_ack_req", mem.mem_req, 1'b0);
    // back-to-back LW 0x10 then SW 0x14 with valid held
    op(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    tick();
    op(1'b1, 3'b010, 32'h0000_0014, 32'hDEAD_BEEF);
    chk("bb1_addr", mem.mem_addr, 32'h0000_0010);
    chk1("bb1_we", mem.mem_we, 1'b0);
    chk("bb1_bmask", {28'b0, mem.mem_bmask}, 32'hF);
    mem.mem_ack = 1'b1;
    mem.mem_rdata = 32'hCAFE_F00D;
    tick();
    mem.mem_ack = 1'b0;
    chk1("bb1_done", done, 1'b1);
    chk("bb1_rdata", rdata, 32'hCAFE_F00D);
    chk1("bb1_ready", ready, 1'b0);
    tick();
    chk1("bb_idle_ready", ready, 1'b1);
    chk1("bb_idle_done", done, 1'b0);
    tick();
    valid = 1'b0;
    chk1("bb2_req", mem.mem_req, 1'b1);
    chk1("bb2_we", mem.mem_we, 1'b1);
    chk("bb2_addr", mem.mem_addr, 32'h0000_0014);
    chk("bb2_wdata", mem.mem_wdata, 32'hDEAD_BEEF);
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    chk1("bb2_done", done, 1'b1);
    chk("bb2_rdata", rdata, 32'h0);
    tick();
    chk1("bb2_done_off", done, 1'b0);
    tick();
    chk1("bb_no_dup_req", mem.mem_req, 1'b0);
    chk1("bb_no_dup_ready", ready, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
